// File: rtl/fifo_uart_tx.sv
// Byte serializer draining an 8-bit synchronous FIFO into an asynchronous serial frame:
// start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_r_en,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_PRE  = TW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic          PAR_INV    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic          r_tx;
    logic          r_busy;
    logic          r_r_en;
    logic          r_byte_done;
    logic          w_timer_last;

    function automatic logic calc_parity(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign w_timer_last = (r_timer == TIMER_LAST);

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign fifo_r_en = r_r_en;
    assign byte_done = r_byte_done;

    // Frame sequencer; outputs are registered and set for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_parity    <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_r_en      <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx        <= 1'b1;
                    r_byte_done <= 1'b0;
                    r_timer     <= '0;
                    if (enable && !fifo_empty) begin
                        r_state <= S_READ;
                        r_r_en  <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_r_en  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_READ: begin
                    r_r_en  <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // FIFO output is valid only during this cycle.
                    r_shift  <= fifo_data;
                    r_parity <= calc_parity(fifo_data, PAR_INV);
                    r_tx     <= 1'b0;
                    r_timer  <= '0;
                    r_state  <= S_START;
                end
                S_START: begin
                    if (w_timer_last) begin
                        r_timer   <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_timer <= r_timer + TW'(1'b1);
                    end
                end
                S_DATA: begin
                    if (w_timer_last) begin
                        r_timer <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1'b1);
                    end
                end
                S_PARITY: begin
                    if (w_timer_last) begin
                        r_timer   <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_timer <= r_timer + TW'(1'b1);
                    end
                end
                S_STOP: begin
                    // r_bit_idx counts stop bits here; byte_done is raised one cycle early so it lands on the last cycle.
                    if (w_timer_last) begin
                        r_timer <= '0;
                        if (r_bit_idx == STOP_LAST) begin
                            r_bit_idx   <= 3'd0;
                            r_busy      <= 1'b0;
                            r_byte_done <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1'b1);
                        if ((r_timer == TIMER_PRE) && (r_bit_idx == STOP_LAST)) begin
                            r_byte_done <= 1'b1;
                        end else begin
                            r_byte_done <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_tx        <= 1'b1;
                    r_busy      <= 1'b0;
                    r_r_en      <= 1'b0;
                    r_byte_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
